run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
Top-level run controller that sequences the 9-bit processor core through its per-program lifecycle.
- Holds a small table of program entry PCs, written by the bench or host config port.
- On a Start request: launches the core at the selected entry, counts run cycles, and watches the core's halt flag (Ack).
- Reports Done, cycle count and timeout. Sits between the test harness and the core's Start/Ack pins.

Parameters:
PC_W, 10, program counter width (matches InstFetch Target)
NPROG, 4, number of program entry slots (power of 2)
SEL_W, 2, log2(NPROG)
CT_W, 16, cycle counter width
TIMEOUT, 16'hFFF0, max RUN cycles before forced stop

Ports:
Clk  in  1  clock, posedge
Reset  in  1  synchronous, active-high reset
Start  in  1  run request from harness; rising edge is significant
ProgSel  in  SEL_W  program slot to launch, sampled on the Start edge
CfgWrEn  in  1  entry-table write enable
CfgAddr  in  SEL_W  entry-table write slot
CfgData  in  PC_W  entry PC to write
CoreAck  in  1  core halt flag (all-ones instruction)
CoreStart  out  1  drives core Start (PC load and hold)
StartPC  out  PC_W  entry PC presented to the core's InstFetch Target
Busy  out  1  high in LAUNCH and RUN
Done  out  1  high in DONE
Timeout  out  1  high in DONE when the run was force-stopped
CycleCt  out  CT_W  cycles executed in the last or current run

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high on Reset.
- Reset values:
  - state=IDLE.
  - CoreStart=0, StartPC=0, Busy=0, Done=0, Timeout=0, CycleCt=0.
  - Table entries all 0; start edge register=0.
- Start edge: start_req = Start & ~Start_q, with Start_q registered each cycle. A level held high never relaunches.
- States:
  - IDLE: start_req -> LAUNCH. StartPC <= table[ProgSel]; CycleCt <= 0; Timeout <= 0.
  - LAUNCH: exactly 1 cycle. CoreStart=1. CoreAck is ignored because it may reflect stale fetch. Next state RUN.
  - RUN: CoreStart=0.
    - CoreAck=1 -> DONE; CycleCt not incremented that cycle.
    - Else if CycleCt == TIMEOUT-1 -> CycleCt <= TIMEOUT, Timeout <= 1, go to DONE.
    - Else CycleCt <= CycleCt+1.
    - start_req is ignored.
  - DONE: Done=1. CycleCt and Timeout are frozen. start_req -> LAUNCH, same actions as from IDLE.
- Latency:
  - Start edge to CoreStart high is 1 cycle.
  - CoreAck high in RUN to Done high is 1 cycle.
- Entry table:
  - A write is visible the next cycle. Writes are accepted in every state.
  - A write to the slot being selected in the same cycle as start_req launches with the old value.
- StartPC is held stable from LAUNCH through DONE.
- CycleCt never wraps; it saturates at TIMEOUT.
- Reset asserted in any state returns to IDLE next edge with the reset values above. The table is cleared.

Optional Feature:
SINGLE_STEP_EN
- With the macro: adds inputs StepMode (1) and Step (1), and output CoreEn (1).
  - In RUN with StepMode=1, CoreEn pulses high for one cycle per Step rising edge.
  - CycleCt counts only enabled cycles.
  - The timeout check applies to enabled cycles only.
  - CoreAck is sampled only in the cycle after a CoreEn pulse.
  - With StepMode=0, CoreEn=Busy.
- Without the macro: no extra ports. The core free-runs (implicit enable=1) and behaviour is as above.

Decomposition:
- Package definitions gets:
  - typedef enum logic[1:0] {RS_IDLE, RS_LAUNCH, RS_RUN, RS_DONE} run_state_t
  - localparam defaults for PC_W, CT_W, TIMEOUT
- Sub-module run_entry_table: NPROG x PC_W register array with one synchronous write port, one combinational read port, and synchronous clear on Reset.

Test Plan:
1. Reset, write slot2=10'h040, ProgSel=2, Start 0->1 -> CoreStart high exactly 1 cycle later, for 1 cycle; StartPC=10'h040; Busy=1.
2. CoreAck raised 25 cycles after LAUNCH -> Done=1 next cycle, CycleCt=25, Timeout=0; Start held high keeps state DONE.
3. CoreAck never rises -> Done=1, Timeout=1, CycleCt=16'hFFF0 after TIMEOUT RUN cycles; a new Start edge relaunches with CycleCt cleared to 0.
4. CfgWrEn on slot1=10'h100 in the same cycle as a Start edge with ProgSel=1 (old value 0) -> StartPC=0; the next launch uses 10'h100.
5. Reset asserted mid-RUN (CycleCt=7) -> next cycle IDLE, all outputs 0, table slots read 0.
6. With SINGLE_STEP_EN and StepMode=1: 3 Step pulses -> 3 CoreEn cycles, CycleCt=3; CoreAck after the 3rd pulse -> Done.

Source files
------------

// File: rtl/run_sequencer_pkg.sv
// Shared types and default sizes for the run sequencer.
package run_sequencer_pkg;

   // Lifecycle of one program run on the core.
   typedef enum logic [1:0] {
      RS_IDLE,
      RS_LAUNCH,
      RS_RUN,
      RS_DONE
   } run_state_t;

   localparam int unsigned      DEF_PC_W    = 10;
   localparam int unsigned      DEF_NPROG   = 4;
   localparam int unsigned      DEF_SEL_W   = 2;
   localparam int unsigned      DEF_CT_W    = 16;
   localparam logic [15:0]      DEF_TIMEOUT = 16'hFFF0;

endpackage : run_sequencer_pkg

// File: rtl/run_sequencer_entry_table.sv
// Program entry-PC table: one synchronous write port, one combinational
// read port, cleared by the synchronous Reset.
module run_entry_table
   import run_sequencer_pkg::*;
#(
   parameter int unsigned PC_W  = DEF_PC_W,
   parameter int unsigned NPROG = DEF_NPROG,
   parameter int unsigned SEL_W = DEF_SEL_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [SEL_W-1:0] wr_addr,
   input  logic [PC_W-1:0]  wr_data,
   input  logic [SEL_W-1:0] rd_addr,
   output logic [PC_W-1:0]  rd_data
);

   logic [PC_W-1:0] table_q [NPROG];
   logic [PC_W-1:0] table_d [NPROG];

   // Next table contents: apply the pending write, if any.
   always_comb begin
      // NOTE: copy the current contents first so every path assigns table_d and no latch is inferred.
      table_d = table_q;
      if (wr_en) begin
         table_d[wr_addr] = wr_data;
      end
   end

   // Table storage; a write becomes visible the cycle after it is issued.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: this small array is cleared on reset so an unwritten slot always launches at PC 0.
         table_q <= '{default: '0};
      end else begin
         // NOTE: registers update with non-blocking assignments; combinational blocks use blocking ones.
         table_q <= table_d;
      end
   end

   // Read is combinational, so a same-cycle write is not yet seen.
   assign rd_data = table_q[rd_addr];

endmodule : run_entry_table

// File: rtl/run_sequencer.sv
// Run sequencer: launches the core at a selected entry PC, counts run
// cycles, watches the core halt flag and reports Done / Timeout.
// Optional macro SINGLE_STEP_EN adds StepMode/Step inputs and CoreEn output
// for stepping the core one enabled cycle per Step rising edge.
module run_sequencer
   import run_sequencer_pkg::*;
#(
   parameter int unsigned      PC_W    = DEF_PC_W,
   parameter int unsigned      NPROG   = DEF_NPROG,
   parameter int unsigned      SEL_W   = DEF_SEL_W,
   parameter int unsigned      CT_W    = DEF_CT_W,
   parameter logic [CT_W-1:0]  TIMEOUT = DEF_TIMEOUT
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [SEL_W-1:0] ProgSel,
   input  logic             CfgWrEn,
   input  logic [SEL_W-1:0] CfgAddr,
   input  logic [PC_W-1:0]  CfgData,
   input  logic             CoreAck,
`ifdef SINGLE_STEP_EN
   input  logic             StepMode,
   input  logic             Step,
   output logic             CoreEn,
`endif
   output logic             CoreStart,
   output logic [PC_W-1:0]  StartPC,
   output logic             Busy,
   output logic             Done,
   output logic             Timeout,
   output logic [CT_W-1:0]  CycleCt
);

   run_state_t      state_q,    state_d;
   logic            start_q,    start_d;
   logic [PC_W-1:0] start_pc_q, start_pc_d;
   logic [CT_W-1:0] cycle_ct_q, cycle_ct_d;
   logic            timeout_q,  timeout_d;

   logic            start_req;
   logic [PC_W-1:0] entry_pc;
   logic            run_en;     // core executes this cycle
   logic            ack_valid;  // CoreAck may be trusted this cycle

   run_entry_table #(
      .PC_W  (PC_W),
      .NPROG (NPROG),
      .SEL_W (SEL_W)
   ) u_table (
      .clk     (Clk),
      .reset   (Reset),
      .wr_en   (CfgWrEn),
      .wr_addr (CfgAddr),
      .wr_data (CfgData),
      .rd_addr (ProgSel),
      .rd_data (entry_pc)
   );

   assign start_req = Start & ~start_q;

`ifdef SINGLE_STEP_EN
   logic step_q,    step_d;
   logic en_prev_q, en_prev_d;
   logic step_pulse;

   assign step_pulse = (state_q == RS_RUN) && Step && !step_q;

   // Step edge tracking; CoreAck is only meaningful right after a step.
   always_comb begin
      step_d    = Step;
      en_prev_d = StepMode && step_pulse;
      run_en    = StepMode ? step_pulse : 1'b1;
      ack_valid = StepMode ? en_prev_q : 1'b1;
      CoreEn    = StepMode ? step_pulse : Busy;
   end

   // Step edge and previous-enable registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         step_q    <= 1'b0;
         en_prev_q <= 1'b0;
      end else begin
         step_q    <= step_d;
         en_prev_q <= en_prev_d;
      end
   end
`else
   assign run_en    = 1'b1;
   assign ack_valid = 1'b1;
`endif

   // Next-state and datapath updates for the run lifecycle.
   always_comb begin
      state_d    = state_q;
      start_d    = Start;
      start_pc_d = start_pc_q;
      cycle_ct_d = cycle_ct_q;
      timeout_d  = timeout_q;
      case (state_q)
         RS_IDLE, RS_DONE: begin
            if (start_req) begin
               state_d    = RS_LAUNCH;
               start_pc_d = entry_pc;
               cycle_ct_d = '0;
               timeout_d  = 1'b0;
            end
         end
         RS_LAUNCH: begin
            // CoreAck may still reflect the previous program's fetch.
            state_d = RS_RUN;
         end
         RS_RUN: begin
            if (ack_valid && CoreAck) begin
               state_d = RS_DONE;
            end else if (run_en) begin
               if (cycle_ct_q == TIMEOUT - 1'b1) begin
                  cycle_ct_d = TIMEOUT;
                  timeout_d  = 1'b1;
                  state_d    = RS_DONE;
               end else begin
                  cycle_ct_d = cycle_ct_q + 1'b1;
               end
            end
         end
         default: state_d = RS_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= RS_IDLE;
         start_q    <= 1'b0;
         start_pc_q <= '0;
         cycle_ct_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         start_pc_q <= start_pc_d;
         cycle_ct_q <= cycle_ct_d;
         timeout_q  <= timeout_d;
      end
   end

   assign CoreStart = (state_q == RS_LAUNCH);
   assign Busy      = (state_q == RS_LAUNCH) || (state_q == RS_RUN);
   assign Done      = (state_q == RS_DONE);
   assign Timeout   = timeout_q;
   assign StartPC   = start_pc_q;
   assign CycleCt   = cycle_ct_q;

endmodule : run_sequencer

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer (define SINGLE_STEP_EN to cover stepping).
module tb_run_sequencer;

   localparam int PC_W  = 10;
   localparam int SEL_W = 2;
   localparam int CT_W  = 16;

   logic             Clk = 1'b0;
   logic             Reset;
   logic             Start;
   logic [SEL_W-1:0] ProgSel;
   logic             CfgWrEn;
   logic [SEL_W-1:0] CfgAddr;
   logic [PC_W-1:0]  CfgData;
   logic             CoreAck;
   logic             CoreStart;
   logic [PC_W-1:0]  StartPC;
   logic             Busy;
   logic             Done;
   logic             Timeout;
   logic [CT_W-1:0]  CycleCt;
`ifdef SINGLE_STEP_EN
   logic             StepMode;
   logic             Step;
   logic             CoreEn;
`endif

   always #5 Clk = ~Clk;

   run_sequencer dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .ProgSel   (ProgSel),
      .CfgWrEn   (CfgWrEn),
      .CfgAddr   (CfgAddr),
      .CfgData   (CfgData),
      .CoreAck   (CoreAck),
`ifdef SINGLE_STEP_EN
      .StepMode  (StepMode),
      .Step      (Step),
      .CoreEn    (CoreEn),
`endif
      .CoreStart (CoreStart),
      .StartPC   (StartPC),
      .Busy      (Busy),
      .Done      (Done),
      .Timeout   (Timeout),
      .CycleCt   (CycleCt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance n clock edges, then settle 1 time unit past the edge.
   task automatic tick(input int n = 1);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   initial begin
      int n;
      Reset   = 1'b1;
      Start   = 1'b0;
      ProgSel = '0;
      CfgWrEn = 1'b0;
      CfgAddr = '0;
      CfgData = '0;
      CoreAck = 1'b0;
`ifdef SINGLE_STEP_EN
      StepMode = 1'b0;
      Step     = 1'b0;
`endif
      tick(2);
      check("rst_corestart", CoreStart, 0);
      check("rst_startpc",   StartPC,   0);
      check("rst_busy",      Busy,      0);
      check("rst_done",      Done,      0);
      check("rst_timeout",   Timeout,   0);
      check("rst_cyclect",   CycleCt,   0);

      // 1: launch slot 2 at 0x040
      Reset   = 1'b0;
      CfgWrEn = 1'b1; CfgAddr = 2'd2; CfgData = 10'h040;
      tick();
      CfgWrEn = 1'b0;
      ProgSel = 2'd2; Start = 1'b1;
      check("t1_no_early_corestart", CoreStart, 0);
      tick();
      check("t1_corestart", CoreStart, 1);
      check("t1_startpc",   StartPC,   10'h040);
      check("t1_busy",      Busy,      1);
`ifdef SINGLE_STEP_EN
      check("t1_coreen_eq_busy", CoreEn, 1);
`endif
      tick();
      check("t1_corestart_1cyc", CoreStart, 0);
      check("t1_busy_run",       Busy,      1);

      // 2: ack after 25 counted RUN cycles
      tick(25);
      check("t2_cyclect_pre", CycleCt, 25);
      CoreAck = 1'b1;
      check("t2_not_done_yet", Done, 0);
      tick();
      CoreAck = 1'b0;
      check("t2_done",    Done,    1);
      check("t2_cyclect", CycleCt, 25);
      check("t2_timeout", Timeout, 0);
      check("t2_busy",    Busy,    0);
      tick(3);
      check("t2_level_no_relaunch", Done,    1);
      check("t2_cyclect_frozen",    CycleCt, 25);

      // 3: no ack -> forced stop after TIMEOUT RUN cycles
      Start = 1'b0;
      tick();
      Start = 1'b1;
      tick();
      check("t3_launch_ct0", CycleCt, 0);
      check("t3_launch_busy", Busy, 1);
      tick();
      n = 0;
      while (!Done && n < 70000) begin
         tick();
         n++;
      end
      check("t3_run_cycles", n,       32'd65520);
      check("t3_done",       Done,    1);
      check("t3_timeout",    Timeout, 1);
      check("t3_cyclect",    CycleCt, 16'hFFF0);
      tick(2);
      check("t3_cyclect_sat", CycleCt, 16'hFFF0);
      Start = 1'b0;
      tick();
      Start = 1'b1;
      tick();
      check("t3_relaunch_ct",      CycleCt, 0);
      check("t3_relaunch_timeout", Timeout, 0);
      check("t3_relaunch_start",   CoreStart, 1);
      tick();
      CoreAck = 1'b1;
      tick();
      CoreAck = 1'b0;
      check("t3_done_ct0", CycleCt, 0);
      Start = 1'b0;
      tick();

      // 4: same-cycle write launches with old value
      CfgWrEn = 1'b1; CfgAddr = 2'd1; CfgData = 10'h100;
      ProgSel = 2'd1; Start = 1'b1;
      tick();
      CfgWrEn = 1'b0;
      check("t4_old_value", StartPC, 0);
      tick();
      check("t4_held_run", StartPC, 0);
      CoreAck = 1'b1;
      tick();
      CoreAck = 1'b0;
      check("t4_held_done", StartPC, 0);
      Start = 1'b0;
      tick();
      Start = 1'b1;
      tick();
      check("t4_new_value", StartPC, 10'h100);

      // 5: reset mid-run
      tick(8);
      check("t5_cyclect7", CycleCt, 7);
      Reset = 1'b1;
      Start = 1'b0;
      tick();
      check("t5_busy",    Busy,      0);
      check("t5_done",    Done,      0);
      check("t5_cs",      CoreStart, 0);
      check("t5_pc",      StartPC,   0);
      check("t5_ct",      CycleCt,   0);
      check("t5_timeout", Timeout,   0);
      Reset = 1'b0;
      tick();
      ProgSel = 2'd2; Start = 1'b1;
      tick();
      check("t5_slot2_cleared", StartPC, 0);
      tick();
      CoreAck = 1'b1;
      tick();
      CoreAck = 1'b0;
      Start = 1'b0;
      tick();
      ProgSel = 2'd1; Start = 1'b1;
      tick();
      check("t5_slot1_cleared", StartPC, 0);

`ifdef SINGLE_STEP_EN
      // 6: single stepping
      StepMode = 1'b1;
      tick();
      check("t6_no_en", CoreEn, 0);
      CoreAck = 1'b1;
      tick();
      CoreAck = 1'b0;
      check("t6_ack_ignored", Busy,    1);
      check("t6_ct0",         CycleCt, 0);
      for (int i = 0; i < 3; i++) begin
         Step = 1'b1;
         check("t6_en_pulse", CoreEn, 1);
         tick();
         Step = 1'b0;
         if (i == 2) CoreAck = 1'b1;
         check("t6_en_low", CoreEn, 0);
         tick();
      end
      CoreAck = 1'b0;
      check("t6_done", Done,    1);
      check("t6_ct3",  CycleCt, 3);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_run_sequencer
